// File: rtl/iserdes_10bit_word_aligner_if.sv
// Signal bundle between the 1:10 deserializer side and the word aligner.
// The master drives raw words and control; the slave (aligner) returns aligned data and status.
interface iserdes_10bit_word_aligner_if;
  logic [9:0] data_in;
  logic       train_en;
  logic       realign;
  logic [9:0] data_out;
  logic       data_valid;
  logic       locked;
  logic [3:0] bit_offset;
  logic       align_err;

  modport master (
    output data_in, train_en, realign,
    input  data_out, data_valid, locked, bit_offset, align_err
  );

  modport slave (
    input  data_in, train_en, realign,
    output data_out, data_valid, locked, bit_offset, align_err
  );
endinterface

// File: rtl/iserdes_10bit_word_aligner.sv
// Finds the bit offset of the training word in a 1:10 deserialized stream,
// locks onto it and emits word-aligned 10-bit data.
module iserdes_10bit_word_aligner #(
  parameter logic [9:0]  TRAIN_PATTERN = 10'h3E0,
  parameter int unsigned LOCK_COUNT    = 16,
  parameter int unsigned ERR_LIMIT     = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  iserdes_10bit_word_aligner_if.slave   bus
);

  localparam int unsigned MCW = $clog2(LOCK_COUNT + 1);
  localparam int unsigned ECW = $clog2(ERR_LIMIT + 1);

  typedef enum logic [1:0] {SEARCH, VERIFY, LOCKED} state_t;

  state_t         state_q, state_d;
  logic [9:0]     prev_q;
  logic [9:0]     data_out_q;
  logic [3:0]     off_q, off_d, off_inc;
  logic [MCW-1:0] mcnt_q, mcnt_d;
  logic [ECW-1:0] ecnt_q, ecnt_d;
  logic           valid_q;
  logic           aerr_q, aerr_d;
  logic [19:0]    window;
  logic [9:0]     cand;
  logic           match;

  // Earlier word sits in the low half so offset k picks bits k..k+9 of the serial stream.
  assign window  = {bus.data_in, prev_q};
  assign cand    = 10'(window >> off_q);
  assign match   = (cand == TRAIN_PATTERN);
  assign off_inc = (off_q == 4'd9) ? '0 : off_q + 4'd1;

  always_comb begin
    state_d = state_q;
    off_d   = off_q;
    mcnt_d  = mcnt_q;
    ecnt_d  = ecnt_q;
    aerr_d  = 1'b0;
    if (bus.realign) begin
      state_d = SEARCH;
      off_d   = '0;
      mcnt_d  = '0;
      ecnt_d  = '0;
    end else if (bus.train_en) begin
      unique case (state_q)
        SEARCH: begin
          if (match) begin
            mcnt_d  = MCW'(1);
            state_d = (LOCK_COUNT == 1) ? LOCKED : VERIFY;
          end else begin
            off_d = off_inc;
          end
        end
        VERIFY: begin
          if (match) begin
            if (mcnt_q == MCW'(LOCK_COUNT - 1)) begin
              state_d = LOCKED;
              mcnt_d  = MCW'(LOCK_COUNT);
            end else begin
              mcnt_d = mcnt_q + MCW'(1);
            end
          end else begin
            state_d = SEARCH;
            mcnt_d  = '0;
            off_d   = off_inc;
          end
        end
        LOCKED: begin
          if (match) begin
            ecnt_d = '0;
          end else if (ecnt_q == ECW'(ERR_LIMIT - 1)) begin
            // Offset is kept so the old alignment is retried first.
            state_d = SEARCH;
            ecnt_d  = '0;
            mcnt_d  = '0;
            aerr_d  = 1'b1;
          end else begin
            ecnt_d = ecnt_q + ECW'(1);
          end
        end
        default: state_d = SEARCH;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= SEARCH;
      prev_q     <= '0;
      data_out_q <= '0;
      off_q      <= '0;
      mcnt_q     <= '0;
      ecnt_q     <= '0;
      valid_q    <= 1'b0;
      aerr_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      prev_q     <= bus.data_in;
      data_out_q <= cand;
      off_q      <= off_d;
      mcnt_q     <= mcnt_d;
      ecnt_q     <= ecnt_d;
      valid_q    <= (state_d == LOCKED);
      aerr_q     <= aerr_d;
    end
  end

  assign bus.data_out   = data_out_q;
  assign bus.data_valid = valid_q;
  assign bus.locked     = (state_q == LOCKED);
  assign bus.bit_offset = off_q;
  assign bus.align_err  = aerr_q;

endmodule

// File: tb/tb_iserdes_10bit_word_aligner.sv
// Directed and randomized bench for the word aligner, checked cycle by cycle
// against a serial-bitstream reference model.
module tb_iserdes_10bit_word_aligner;

  localparam logic [9:0]  P     = 10'h3E0;
  localparam int unsigned LOCKN = 16;
  localparam int unsigned ERRN  = 4;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  iserdes_10bit_word_aligner_if bus ();

  iserdes_10bit_word_aligner #(
    .TRAIN_PATTERN (P),
    .LOCK_COUNT    (LOCKN),
    .ERR_LIMIT     (ERRN)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: last 20 received bits in wire order (index 0 = oldest).
  bit         hist[$];
  int         m_off;
  int         m_run;
  int         m_err;
  bit         m_locked;
  logic [9:0] e_out;
  bit         e_aerr;

  task automatic model_reset();
    hist.delete();
    for (int i = 0; i < 10; i++) hist.push_back(1'b0);
    m_off = 0; m_run = 0; m_err = 0; m_locked = 0;
    e_out = '0; e_aerr = 0;
  endtask

  task automatic model_step(input bit r, input logic [9:0] d, input bit te, input bit ra);
    logic [9:0] cand;
    bit hit;
    if (r) begin
      model_reset();
      return;
    end
    for (int j = 0; j < 10; j++) hist.push_back(d[j]);
    for (int i = 0; i < 10; i++) cand[i] = hist[hist.size() - 20 + m_off + i];
    while (hist.size() > 10) void'(hist.pop_front());
    hit    = (cand == P);
    e_out  = cand;
    e_aerr = 0;
    if (ra) begin
      m_off = 0; m_run = 0; m_err = 0; m_locked = 0;
    end else if (te) begin
      if (m_locked) begin
        if (hit) m_err = 0;
        else begin
          m_err++;
          if (m_err == ERRN) begin
            m_locked = 0; m_err = 0; m_run = 0; e_aerr = 1;
          end
        end
      end else if (hit) begin
        m_run++;
        if (m_run == LOCKN) m_locked = 1;
      end else begin
        m_run = 0;
        m_off = (m_off + 1) % 10;
      end
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input bit r, input logic [9:0] d, input bit te, input bit ra);
    rst = r; bus.data_in = d; bus.train_en = te; bus.realign = ra;
    @(posedge clk);
    model_step(r, d, te, ra);
    #1;
    chk("data_out",   32'(bus.data_out),   32'(e_out));
    chk("data_valid", 32'(bus.data_valid), 32'(m_locked));
    chk("locked",     32'(bus.locked),     32'(m_locked));
    chk("bit_offset", 32'(bus.bit_offset), 32'(m_off));
    chk("align_err",  32'(bus.align_err),  32'(e_aerr));
  endtask

  // Word seen by the deserializer when the repeating training stream is delayed k bits.
  function automatic logic [9:0] rot(input int unsigned k);
    logic [19:0] t;
    t = {P, P} << k;
    return t[19:10];
  endfunction

  task automatic run(input int n, input logic [9:0] d, input bit te);
    for (int i = 0; i < n; i++) step(1'b0, d, te, 1'b0);
  endtask

  initial begin
    int max_off;
    int k;
    logic [9:0] w;
    checks = 0; errors = 0;
    rst = 1'b1; bus.data_in = '0; bus.train_en = 1'b0; bus.realign = 1'b0;
    model_reset();

    // T1 reset with random data
    for (int i = 0; i < 3; i++) step(1'b1, 10'($urandom), 1'b1, 1'b0);
    chk("t1_locked", 32'(bus.locked), 32'd0);
    chk("t1_offset", 32'(bus.bit_offset), 32'd0);

    // T2 lock at offset 3
    run(3, rot(3), 1'b1);
    chk("t2_offset", 32'(bus.bit_offset), 32'd3);
    run(15, rot(3), 1'b1);
    chk("t2_not_yet", 32'(bus.locked), 32'd0);
    run(1, rot(3), 1'b1);
    chk("t2_locked", 32'(bus.locked), 32'd1);
    chk("t2_data", 32'(bus.data_out), 32'(P));

    // T3 wrap: search starts at 1 (prev cleared) and must walk through 9 back to 0
    step(1'b1, '0, 1'b0, 1'b0);
    max_off = 0;
    for (int i = 0; i < 10; i++) begin
      step(1'b0, rot(0), 1'b1, 1'b0);
      if (int'(bus.bit_offset) > max_off) max_off = int'(bus.bit_offset);
    end
    chk("t3_max_off", 32'(max_off), 32'd9);
    chk("t3_wrapped", 32'(bus.bit_offset), 32'd0);
    run(16, rot(0), 1'b1);
    chk("t3_locked", 32'(bus.locked), 32'd1);
    chk("t3_offset", 32'(bus.bit_offset), 32'd0);

    // T4 verify failure at offset 5
    step(1'b1, '0, 1'b0, 1'b0);
    run(5, rot(5), 1'b1);
    chk("t4_offset", 32'(bus.bit_offset), 32'd5);
    run(7, rot(5), 1'b1);
    step(1'b0, rot(5) ^ 10'h001, 1'b1, 1'b0);
    chk("t4_retry_off", 32'(bus.bit_offset), 32'd6);
    chk("t4_unlocked", 32'(bus.locked), 32'd0);
    run(9, rot(5), 1'b1);
    chk("t4_back5", 32'(bus.bit_offset), 32'd5);
    run(16, rot(5), 1'b1);
    chk("t4_locked", 32'(bus.locked), 32'd1);

    // T5 loss of lock at offset 2, then payload corruption ignored
    step(1'b1, '0, 1'b0, 1'b0);
    run(18, rot(2), 1'b1);
    chk("t5_locked", 32'(bus.locked), 32'd1);
    run(3, rot(2) ^ 10'h001, 1'b1);
    chk("t5_hold", 32'(bus.locked), 32'd1);
    run(1, rot(2) ^ 10'h001, 1'b1);
    chk("t5_aerr", 32'(bus.align_err), 32'd1);
    chk("t5_dropped", 32'(bus.locked), 32'd0);
    chk("t5_offset", 32'(bus.bit_offset), 32'd2);
    run(1, rot(2), 1'b1);
    chk("t5_aerr_pulse", 32'(bus.align_err), 32'd0);
    run(15, rot(2), 1'b1);
    chk("t5_relock", 32'(bus.locked), 32'd1);
    run(4, rot(2) ^ 10'h001, 1'b0);
    run(2, rot(2), 1'b1);
    chk("t5_payload", 32'(bus.locked), 32'd1);

    // T6 realign beats a coincident 4th error
    step(1'b1, '0, 1'b0, 1'b0);
    run(23, rot(7), 1'b1);
    chk("t6_locked", 32'(bus.locked), 32'd1);
    chk("t6_off7", 32'(bus.bit_offset), 32'd7);
    run(3, rot(7) ^ 10'h001, 1'b1);
    step(1'b0, rot(7) ^ 10'h001, 1'b1, 1'b1);
    chk("t6_unlocked", 32'(bus.locked), 32'd0);
    chk("t6_offset", 32'(bus.bit_offset), 32'd0);
    chk("t6_no_aerr", 32'(bus.align_err), 32'd0);
    step(1'b0, rot(7) ^ 10'h001, 1'b1, 1'b0);
    chk("t6_no_aerr2", 32'(bus.align_err), 32'd0);

    // Randomized traffic: mostly training at a slowly changing delay, with noise
    k = int'($urandom_range(0, 9));
    for (int n = 0; n < 3000; n++) begin
      int r;
      r = int'($urandom_range(0, 99));
      if ($urandom_range(0, 199) == 0) k = int'($urandom_range(0, 9));
      w = rot(k);
      if (r < 8) w = w ^ 10'(1 << $urandom_range(0, 9));
      else if (r < 12) w = 10'($urandom);
      step($urandom_range(0, 999) == 0, w, $urandom_range(0, 9) != 0,
           $urandom_range(0, 299) == 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
